// File: rtl/if_instr_queue.sv
// if_instr_queue
//   Superscalar instruction queue sitting between fetch and decode. Fetch
//   pushes up to FETCH_WIDTH in-order instructions per cycle (PC, instruction
//   word, predicted-taken flag, predicted target); decode drains up to
//   FETCH_WIDTH per cycle, oldest entry always on lane 0. A flush discards all
//   contents, e.g. on a branch mispredict redirect.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   flush_i       discard every entry at this edge (same-cycle push/pop dropped)
//   in_valid_i    per-lane write valid, contiguous from lane 0
//   in_pc_i       lane PCs              (lane k at [k*PC_BITS +: PC_BITS])
//   in_instr_i    lane instruction words
//   in_taken_i    lane predicted-taken flags
//   in_target_i   lane predicted targets
//   in_ready_o    a full bundle can be accepted this cycle
//   out_valid_o   lane k holds the k-th oldest entry
//   out_pc_o, out_instr_o, out_taken_o, out_target_o  output lane data
//   out_ready_i   per-lane decode accept, contiguous from lane 0
//   count_o       number of occupied entries

module if_instr_queue #(
  parameter int PC_BITS     = 32,
  parameter int INSTR_BITS  = 32,
  parameter int FETCH_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush_i,
  input  logic [FETCH_WIDTH-1:0]            in_valid_i,
  input  logic [FETCH_WIDTH*PC_BITS-1:0]    in_pc_i,
  input  logic [FETCH_WIDTH*INSTR_BITS-1:0] in_instr_i,
  input  logic [FETCH_WIDTH-1:0]            in_taken_i,
  input  logic [FETCH_WIDTH*PC_BITS-1:0]    in_target_i,
  output logic                              in_ready_o,
  output logic [FETCH_WIDTH-1:0]            out_valid_o,
  output logic [FETCH_WIDTH*PC_BITS-1:0]    out_pc_o,
  output logic [FETCH_WIDTH*INSTR_BITS-1:0] out_instr_o,
  output logic [FETCH_WIDTH-1:0]            out_taken_o,
  output logic [FETCH_WIDTH*PC_BITS-1:0]    out_target_o,
  input  logic [FETCH_WIDTH-1:0]            out_ready_i,
  output logic [$clog2(DEPTH):0]            count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Highest occupancy that still leaves room for a whole bundle.
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - FETCH_WIDTH);

  logic [PC_BITS-1:0]    pc_mem     [DEPTH];
  logic [INSTR_BITS-1:0] instr_mem  [DEPTH];
  logic                  taken_mem  [DEPTH];
  logic [PC_BITS-1:0]    target_mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             push_en;
  logic [CNT_W-1:0] n_push;
  logic [CNT_W-1:0] n_pop;

  // Ready depends only on the registered count, so decode backpressure never
  // reaches fetch combinationally. A pop in a full cycle therefore cannot
  // enable a push in that same cycle.
  assign in_ready_o = (count <= READY_MAX);
  assign push_en    = in_ready_o;
  assign count_o    = count;

  always_comb begin
    n_push = '0;
    if (push_en) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        n_push = n_push + CNT_W'(in_valid_i[k]);
      end
    end
  end

  // Only the leading contiguous run of valid & ready lanes is popped; a gap
  // in out_ready_i stops the run so ordering is never broken.
  always_comb begin
    logic run;
    n_pop = '0;
    run   = 1'b1;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (run && out_valid_o[k] && out_ready_i[k]) begin
        n_pop = n_pop + CNT_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // Read side: lane k shows slot head+k; data is zeroed on empty lanes so
  // the outputs are clean after reset and flush.
  always_comb begin
    out_valid_o  = '0;
    out_pc_o     = '0;
    out_instr_o  = '0;
    out_taken_o  = '0;
    out_target_o = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      out_valid_o[k] = (count > CNT_W'(k));
      if (out_valid_o[k]) begin
        out_pc_o[k*PC_BITS +: PC_BITS]          = pc_mem[head + PTR_W'(k)];
        out_instr_o[k*INSTR_BITS +: INSTR_BITS] = instr_mem[head + PTR_W'(k)];
        out_taken_o[k]                          = taken_mem[head + PTR_W'(k)];
        out_target_o[k*PC_BITS +: PC_BITS]      = target_mem[head + PTR_W'(k)];
      end
    end
  end

  // Write side: storage is not reset; stale slots are never visible because
  // visibility is governed by count.
  always_ff @(posedge clk) begin
    if (push_en && !flush_i) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (in_valid_i[k]) begin
          pc_mem[tail + PTR_W'(k)]     <= in_pc_i[k*PC_BITS +: PC_BITS];
          instr_mem[tail + PTR_W'(k)]  <= in_instr_i[k*INSTR_BITS +: INSTR_BITS];
          taken_mem[tail + PTR_W'(k)]  <= in_taken_i[k];
          target_mem[tail + PTR_W'(k)] <= in_target_i[k*PC_BITS +: PC_BITS];
        end
      end
    end
  end

  // Pointers wrap modulo DEPTH by their natural width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_pop);
      tail  <= tail + PTR_W'(n_push);
      count <= count + n_push - n_pop;
    end
  end

endmodule

// File: tb/tb_if_instr_queue.sv
module tb_if_instr_queue;

  localparam int PC_BITS     = 32;
  localparam int INSTR_BITS  = 32;
  localparam int FETCH_WIDTH = 2;
  localparam int DEPTH       = 8;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic [1:0]  in_valid_i;
  logic [63:0] in_pc_i;
  logic [63:0] in_instr_i;
  logic [1:0]  in_taken_i;
  logic [63:0] in_target_i;
  logic        in_ready_o;
  logic [1:0]  out_valid_o;
  logic [63:0] out_pc_o;
  logic [63:0] out_instr_o;
  logic [1:0]  out_taken_o;
  logic [63:0] out_target_o;
  logic [1:0]  out_ready_i;
  logic [3:0]  count_o;

  if_instr_queue #(
    .PC_BITS(PC_BITS), .INSTR_BITS(INSTR_BITS),
    .FETCH_WIDTH(FETCH_WIDTH), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_pc_i(in_pc_i), .in_instr_i(in_instr_i),
    .in_taken_i(in_taken_i), .in_target_i(in_target_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_pc_o(out_pc_o), .out_instr_o(out_instr_o),
    .out_taken_o(out_taken_o), .out_target_o(out_target_o),
    .out_ready_i(out_ready_i), .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        taken;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    logic [1:0]  v;
    logic [31:0] pc;
    logic [1:0]  tk;
    logic [31:0] tgt;
    logic [1:0]  rdy;
    logic        fl;
    logic [3:0]  ecnt;
    logic [1:0]  evld;
    logic        erdy;
  } vec_t;

  ent_t sb[$];
  vec_t tbl[24];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every visible output against the scoreboard contents.
  task automatic check_model();
    cmp("sb_count", 64'(count_o), 64'(sb.size()));
    cmp("sb_in_ready", 64'(in_ready_o), 64'(sb.size() <= DEPTH - FETCH_WIDTH));
    for (int k = 0; k < 2; k++) begin
      cmp("sb_valid", 64'(out_valid_o[k]), 64'(k < sb.size()));
      if (k < sb.size()) begin
        cmp("sb_pc", 64'(out_pc_o[k*32 +: 32]), 64'(sb[k].pc));
        cmp("sb_instr", 64'(out_instr_o[k*32 +: 32]), 64'(sb[k].instr));
        cmp("sb_taken", 64'(out_taken_o[k]), 64'(sb[k].taken));
        cmp("sb_target", 64'(out_target_o[k*32 +: 32]), 64'(sb[k].tgt));
      end
    end
  endtask

  // Called at a negedge: drive inputs, update the scoreboard, cross the
  // posedge, then compare at the following negedge.
  task automatic step(input logic [1:0] v, input logic [31:0] pc0, input logic [1:0] tk,
                      input logic [31:0] tgt, input logic [1:0] rdy, input logic fl);
    int   np;
    bit   acc;
    ent_t e;
    logic [31:0] pcs [2];
    pcs[0] = pc0;
    pcs[1] = pc0 + 32'd4;
    in_valid_i  = v;
    in_pc_i     = {pcs[1], pcs[0]};
    in_instr_i  = {~pcs[1], ~pcs[0]};
    in_taken_i  = tk;
    in_target_i = {tgt, tgt};
    out_ready_i = rdy;
    flush_i     = fl;
    if (fl) begin
      sb.delete();
    end else begin
      acc = (sb.size() <= DEPTH - FETCH_WIDTH);
      np = 0;
      while (np < 2 && np < sb.size() && rdy[np]) np++;
      for (int i = 0; i < np; i++) void'(sb.pop_front());
      if (acc) begin
        for (int k = 0; k < 2; k++) begin
          if (v[k]) begin
            e.pc = pcs[k]; e.instr = ~pcs[k]; e.taken = tk[k]; e.tgt = tgt;
            sb.push_back(e);
          end
        end
      end
    end
    @(negedge clk);
    in_valid_i  = 2'b00;
    out_ready_i = 2'b00;
    flush_i     = 1'b0;
    check_model();
  endtask

  task automatic run_vec(input int i);
    step(tbl[i].v, tbl[i].pc, tbl[i].tk, tbl[i].tgt, tbl[i].rdy, tbl[i].fl);
    cmp($sformatf("vec%0d_count", i), 64'(count_o), 64'(tbl[i].ecnt));
    cmp($sformatf("vec%0d_valid", i), 64'(out_valid_o), 64'(tbl[i].evld));
    cmp($sformatf("vec%0d_in_ready", i), 64'(in_ready_o), 64'(tbl[i].erdy));
  endtask

  function automatic vec_t mk(logic [1:0] v, logic [31:0] pc, logic [1:0] tk, logic [31:0] tgt,
                              logic [1:0] rdy, logic fl, logic [3:0] ecnt, logic [1:0] evld,
                              logic erdy);
    vec_t r;
    r.v = v; r.pc = pc; r.tk = tk; r.tgt = tgt; r.rdy = rdy; r.fl = fl;
    r.ecnt = ecnt; r.evld = evld; r.erdy = erdy;
    return r;
  endfunction

  logic [31:0] prev_pc;

  initial begin
    //            v      pc     tk    tgt    rdy   fl  cnt  vld  rdy
    tbl[0]  = mk(2'b11, 32'h00, 2'b00, 32'h0, 2'b00, 0, 2, 2'b11, 1);
    tbl[1]  = mk(2'b11, 32'h08, 2'b00, 32'h0, 2'b00, 0, 4, 2'b11, 1);
    tbl[2]  = mk(2'b11, 32'h10, 2'b00, 32'h0, 2'b00, 0, 6, 2'b11, 1);
    tbl[3]  = mk(2'b11, 32'h18, 2'b00, 32'h0, 2'b00, 0, 8, 2'b11, 0);
    tbl[4]  = mk(2'b11, 32'h20, 2'b00, 32'h0, 2'b00, 0, 8, 2'b11, 0);
    tbl[5]  = mk(2'b11, 32'h20, 2'b00, 32'h0, 2'b00, 0, 8, 2'b11, 0);
    tbl[6]  = mk(2'b11, 32'h20, 2'b00, 32'h0, 2'b00, 0, 8, 2'b11, 0);
    tbl[7]  = mk(2'b11, 32'h20, 2'b00, 32'h0, 2'b11, 0, 6, 2'b11, 1);
    tbl[8]  = mk(2'b00, 32'h00, 2'b00, 32'h0, 2'b11, 0, 4, 2'b11, 1);
    tbl[9]  = mk(2'b00, 32'h00, 2'b00, 32'h0, 2'b11, 0, 2, 2'b11, 1);
    tbl[10] = mk(2'b00, 32'h00, 2'b00, 32'h0, 2'b11, 0, 0, 2'b00, 1);
    tbl[11] = mk(2'b01, 32'h10, 2'b00, 32'h0, 2'b00, 0, 1, 2'b01, 1);
    tbl[12] = mk(2'b11, 32'h14, 2'b00, 32'h0, 2'b11, 0, 2, 2'b11, 1);
    tbl[13] = mk(2'b00, 32'h00, 2'b00, 32'h0, 2'b11, 0, 0, 2'b00, 1);
    tbl[14] = mk(2'b01, 32'h30, 2'b01, 32'h40, 2'b00, 0, 1, 2'b01, 1);
    tbl[15] = mk(2'b00, 32'h00, 2'b00, 32'h0, 2'b01, 0, 0, 2'b00, 1);
    tbl[16] = mk(2'b11, 32'h50, 2'b00, 32'h0, 2'b00, 0, 2, 2'b11, 1);
    tbl[17] = mk(2'b11, 32'h20, 2'b00, 32'h0, 2'b11, 1, 0, 2'b00, 1);
    tbl[18] = mk(2'b01, 32'h40, 2'b00, 32'h0, 2'b00, 0, 1, 2'b01, 1);
    tbl[19] = mk(2'b11, 32'h60, 2'b00, 32'h0, 2'b00, 0, 3, 2'b11, 1);
    tbl[20] = mk(2'b00, 32'h00, 2'b00, 32'h0, 2'b10, 0, 3, 2'b11, 1);
    tbl[21] = mk(2'b00, 32'h00, 2'b00, 32'h0, 2'b01, 0, 2, 2'b11, 1);
    tbl[22] = mk(2'b11, 32'h70, 2'b00, 32'h0, 2'b00, 0, 4, 2'b11, 1);
    tbl[23] = mk(2'b11, 32'h78, 2'b00, 32'h0, 2'b00, 0, 6, 2'b11, 1);

    rst = 1'b1; flush_i = 1'b0; in_valid_i = '0; in_pc_i = '0; in_instr_i = '0;
    in_taken_i = '0; in_target_i = '0; out_ready_i = '0;
    repeat (2) @(negedge clk);
    cmp("reset_count", 64'(count_o), 64'd0);
    cmp("reset_in_ready", 64'(in_ready_o), 64'd1);
    cmp("reset_valid", 64'(out_valid_o), 64'd0);
    cmp("reset_pc", out_pc_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fill, hold a fifth bundle while full, pop from full.
    for (int i = 0; i <= 7; i++) run_vec(i);

    // Steady state: push 2 / pop 2 each cycle across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      prev_pc = out_pc_o[31:0];
      step(2'b11, 32'h20 + 32'(8 * i), 2'b00, 32'h0, 2'b11, 1'b0);
      cmp("steady_count", 64'(count_o), 64'd6);
      cmp("steady_pc_step", 64'(out_pc_o[31:0]), 64'(prev_pc + 32'd8));
    end

    for (int i = 8; i <= 23; i++) begin
      run_vec(i);
      if (i == 12) cmp("pushpop_pcs", out_pc_o, {32'h18, 32'h14});
      if (i == 14) begin
        cmp("branch_taken", 64'(out_taken_o[0]), 64'd1);
        cmp("branch_target", 64'(out_target_o[31:0]), 64'h40);
      end
      if (i == 18) cmp("post_flush_pc", 64'(out_pc_o[31:0]), 64'h40);
    end

    // Asynchronous reset between clock edges with count=6.
    #2 rst = 1'b1;
    #1;
    cmp("async_rst_count", 64'(count_o), 64'd0);
    cmp("async_rst_valid", 64'(out_valid_o), 64'd0);
    cmp("async_rst_in_ready", 64'(in_ready_o), 64'd1);
    sb.delete();
    #1 rst = 1'b0;
    @(negedge clk);
    step(2'b11, 32'h80, 2'b00, 32'h0, 2'b00, 1'b0);
    cmp("after_rst_count", 64'(count_o), 64'd2);
    cmp("after_rst_pc", out_pc_o, {32'h84, 32'h80});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_instr_queue.md
Name: if_instr_queue

Overview:
- Superscalar instruction queue between the fetch stage and decode.
- Fetch writes up to FETCH_WIDTH in-order instructions per cycle, each with its PC and predicted-branch metadata; decode drains up to FETCH_WIDTH per cycle, oldest first.
- Decouples fetch stalls from decode stalls.
- Discards all contents on a redirect flush, e.g. a mispredicted branch or function-call target.

Parameters:
- PC_BITS, 32, width of PC and predicted target.
- INSTR_BITS, 32, instruction word width.
- FETCH_WIDTH, 2, lanes per side.
- DEPTH, 8, entries; power of 2, DEPTH >= 2*FETCH_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush_i  in  1  discard all entries this cycle.
- in_valid_i  in  FETCH_WIDTH  per-lane write valid; must be contiguous from lane 0.
- in_pc_i  in  FETCH_WIDTH*PC_BITS  lane PCs.
- in_instr_i  in  FETCH_WIDTH*INSTR_BITS  lane instructions.
- in_taken_i  in  FETCH_WIDTH  predicted-taken flag per lane.
- in_target_i  in  FETCH_WIDTH*PC_BITS  predicted target per lane.
- in_ready_o  out  1  queue accepts a full bundle.
- out_valid_o  out  FETCH_WIDTH  lane k holds the k-th oldest entry.
- out_pc_o  out  FETCH_WIDTH*PC_BITS  output PCs.
- out_instr_o  out  FETCH_WIDTH*INSTR_BITS  output instructions.
- out_taken_o  out  FETCH_WIDTH  output predicted-taken flags.
- out_target_o  out  FETCH_WIDTH*PC_BITS  output predicted targets.
- out_ready_i  in  FETCH_WIDTH  per-lane decode accept; must be contiguous from lane 0.
- count_o  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Storage: circular buffer with head pointer (read), tail pointer (write) and occupancy counter. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- Reset (async, rst=1): head=0, tail=0, count=0. Outputs: in_ready_o=1, out_valid_o=0, count_o=0, all data outputs 0. Storage contents are don't-care.
- in_ready_o = (DEPTH - count) >= FETCH_WIDTH. Computed from registered count only, with no combinational path from out_ready_i. Acceptance is all-or-nothing per bundle.
- Push: n_push = popcount(in_valid_i) when in_ready_o=1, else 0. Lane k is written to slot (tail+k) mod DEPTH, and tail advances by n_push.
- in_valid_i with in_ready_o=0: nothing written. Fetch must hold the bundle.
- Output lane k: out_valid_o[k] = (count > k). Data comes from slot (head+k) mod DEPTH. Outputs are driven combinationally from registers.
- Pop: n_pop = number of lanes with out_valid_o[k] & out_ready_i[k]. head advances by n_pop.
- Non-contiguous out_ready_i (a gap) pops only the leading contiguous run.
- count_next = count + n_push - n_pop. Push and pop in the same cycle are both honoured. count never exceeds DEPTH.
- Latency: a pushed entry appears on out_valid_o on the next cycle. There is no same-cycle bypass, including when the queue is empty.
- Flush:
  - flush_i=1 sets head=tail=0 and count=0 at the clock edge.
  - The same-cycle push and pop are discarded; pop has no effect.
  - The next cycle shows out_valid_o=0 and in_ready_o=1.
- Wrap: a bundle straddling slot DEPTH-1 and slot 0 is stored and read in order without a gap.
- Full (count=DEPTH): in_ready_o=0 while out_valid_o stays all 1s. A pop in this cycle does not enable a push in the same cycle.
- Reset asserted mid-operation: the queue clears immediately and asynchronously, and all entries are lost.
- Ordering: strict FIFO in program order. Lane 0 is always the oldest.

Test Plan:
- Reset, then push bundle PCs 0x0/0x4 with out_ready_i=00 → next cycle out_valid_o=11, out_pc_o=0x0/0x4, count_o=2.
- Fill 4 bundles (PCs 0x0..0x1C) with out_ready_i=00 → count_o=8, in_ready_o=0. A fifth bundle held for 3 cycles is not written; count_o stays 8.
- Steady state with push of 2 and pop of 2 every cycle for 20 cycles → count_o constant, and output PCs increment by 8 per cycle across pointer wrap.
- count=1 (PC 0x10), push bundle 0x14/0x18 with out_ready_i=11 → the 0x10 entry is popped. Next cycle out_pc_o=0x14/0x18 and count_o=2.
- Branch entry (taken=1, target=0x40) is popped with its metadata intact. flush_i asserted the same cycle as a push of 0x20/0x24 → next cycle count_o=0 and out_valid_o=00. A push of 0x40 then appears alone on lane 0.
- rst pulsed asynchronously between clock edges with count=6 → count_o=0 and out_valid_o=00 immediately, before the next clk edge.
